// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with fill level, programmable almost-full/empty
// thresholds, standard or first-word-fall-through read, and sticky error flags.
module sync_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned P_SIZE     = $clog2(FIFO_DEPTH) + 1,
    parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int unsigned AE_LEVEL   = 2,
    parameter bit          FWFT       = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_INC,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  R_INC,
    input  logic                  CLR_ERR,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [P_SIZE-1:0]     COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int unsigned AW = P_SIZE - 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [P_SIZE-1:0]     wptr;
    logic [P_SIZE-1:0]     rptr;
    logic [P_SIZE-1:0]     wptr_nxt;
    logic [P_SIZE-1:0]     rptr_nxt;
    logic [P_SIZE-1:0]     count_nxt;
    logic [AW-1:0]         waddr;
    logic [AW-1:0]         raddr;
    logic [AW-1:0]         raddr_nxt;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  ovf_nxt;
    logic                  unf_nxt;
    logic [DATA_WIDTH-1:0] head_nxt;

    // Acceptance, pointer/count and flag next-state
    always_comb begin
        wr_ok     = 1'b0;
        rd_ok     = 1'b0;
        wptr_nxt  = wptr;
        rptr_nxt  = rptr;
        count_nxt = COUNT;
        ovf_nxt   = OVERFLOW;
        unf_nxt   = UNDERFLOW;
        waddr     = wptr[AW-1:0];
        raddr     = rptr[AW-1:0];

        wr_ok = W_INC && !FULL;
        rd_ok = R_INC && !EMPTY;
        if (wr_ok) wptr_nxt = wptr + P_SIZE'(1);
        if (rd_ok) rptr_nxt = rptr + P_SIZE'(1);

        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = COUNT + P_SIZE'(1);
            2'b01:   count_nxt = COUNT - P_SIZE'(1);
            default: count_nxt = COUNT;
        endcase

        // A new error in the same cycle as a clear must survive the clear
        ovf_nxt = (W_INC && FULL)  || (OVERFLOW  && !CLR_ERR);
        unf_nxt = (R_INC && EMPTY) || (UNDERFLOW && !CLR_ERR);
        raddr_nxt = rptr_nxt[AW-1:0];
    end

    // Head word after this edge; bypass when the head slot is being written now
    always_comb begin
        head_nxt = mem[raddr_nxt];
        if (wr_ok && (waddr == raddr_nxt)) head_nxt = WR_DATA;
    end

    // Storage is deliberately not reset
    always_ff @(posedge CLK) begin
        if (!RST && wr_ok) mem[waddr] <= WR_DATA;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr         <= '0;
            rptr         <= '0;
            COUNT        <= '0;
            FULL         <= 1'b0;
            EMPTY        <= 1'b1;
            ALMOST_FULL  <= 1'b0;
            ALMOST_EMPTY <= 1'b1;
            OVERFLOW     <= 1'b0;
            UNDERFLOW    <= 1'b0;
            RD_VALID     <= 1'b0;
            RD_DATA      <= '0;
        end else begin
            wptr         <= wptr_nxt;
            rptr         <= rptr_nxt;
            COUNT        <= count_nxt;
            FULL         <= (count_nxt == P_SIZE'(FIFO_DEPTH));
            EMPTY        <= (count_nxt == '0);
            ALMOST_FULL  <= (count_nxt >= P_SIZE'(AF_LEVEL));
            ALMOST_EMPTY <= (count_nxt <= P_SIZE'(AE_LEVEL));
            OVERFLOW     <= ovf_nxt;
            UNDERFLOW    <= unf_nxt;
            if (FWFT) begin
                RD_VALID <= (count_nxt != '0);
                if (count_nxt != '0) RD_DATA <= head_nxt;
            end else begin
                RD_VALID <= rd_ok;
                if (rd_ok) RD_DATA <= mem[raddr];
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: standard and FWFT instances driven in lockstep,
// checked against a queue-based reference plus directed vector tables.
module tb_sync_fifo_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PS    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          w_inc;
    logic          r_inc;
    logic          clr_err;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] s_rd_data, f_rd_data;
    logic          s_rd_valid, f_rd_valid;
    logic          s_full, f_full, s_empty, f_empty;
    logic          s_af, f_af, s_ae, f_ae;
    logic [PS-1:0] s_count, f_count;
    logic          s_ovf, f_ovf, s_unf, f_unf;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1'b0)) u_std (
        .CLK(clk), .RST(rst), .W_INC(w_inc), .WR_DATA(wr_data), .R_INC(r_inc),
        .CLR_ERR(clr_err), .RD_DATA(s_rd_data), .RD_VALID(s_rd_valid),
        .FULL(s_full), .EMPTY(s_empty), .ALMOST_FULL(s_af), .ALMOST_EMPTY(s_ae),
        .COUNT(s_count), .OVERFLOW(s_ovf), .UNDERFLOW(s_unf)
    );

    sync_fifo_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1'b1)) u_fwft (
        .CLK(clk), .RST(rst), .W_INC(w_inc), .WR_DATA(wr_data), .R_INC(r_inc),
        .CLR_ERR(clr_err), .RD_DATA(f_rd_data), .RD_VALID(f_rd_valid),
        .FULL(f_full), .EMPTY(f_empty), .ALMOST_FULL(f_af), .ALMOST_EMPTY(f_ae),
        .COUNT(f_count), .OVERFLOW(f_ovf), .UNDERFLOW(f_unf)
    );

    // Reference model state
    byte unsigned  q[$];
    bit            m_ovf;
    bit            m_unf;
    bit            m_sv;
    logic [DW-1:0] m_sd;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit            rst;
        bit            w;
        logic [DW-1:0] d;
        bit            r;
        bit            clr;
        int            cnt;
        bit            full;
        bit            empty;
        bit            ovf;
        bit            unf;
        bit            sv;
        logic [DW-1:0] sd;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(bit rs, bit w, logic [DW-1:0] d, bit r, bit c, int cnt,
                                bit fu, bit em, bit ov, bit un, bit sv, logic [DW-1:0] sd);
        vec_t v;
        v.rst = rs; v.w = w; v.d = d; v.r = r; v.clr = c; v.cnt = cnt;
        v.full = fu; v.empty = em; v.ovf = ov; v.unf = un; v.sv = sv; v.sd = sd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Apply the rules of one clock edge to the queue model
    task automatic model_step();
        bit full, empty, wacc, racc;
        if (rst) begin
            q.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_sv = 1'b0; m_sd = '0;
            return;
        end
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        wacc  = w_inc && !full;
        racc  = r_inc && !empty;
        m_ovf = (w_inc && full)  || (m_ovf && !clr_err);
        m_unf = (r_inc && empty) || (m_unf && !clr_err);
        m_sv  = racc;
        if (racc) m_sd = q.pop_front();
        if (wacc) q.push_back(wr_data);
    endtask

    task automatic check_model();
        int n;
        n = q.size();
        chk("count",      32'(s_count), 32'(n));
        chk("full",       32'(s_full),  32'(n == DEPTH));
        chk("empty",      32'(s_empty), 32'(n == 0));
        chk("almost_full",  32'(s_af),  32'(n >= DEPTH - 2));
        chk("almost_empty", 32'(s_ae),  32'(n <= 2));
        chk("overflow",   32'(s_ovf),   32'(m_ovf));
        chk("underflow",  32'(s_unf),   32'(m_unf));
        chk("std_valid",  32'(s_rd_valid), 32'(m_sv));
        chk("std_data",   32'(s_rd_data),  32'(m_sd));
        chk("fwft_count", 32'(f_count), 32'(n));
        chk("fwft_flags", 32'({f_full, f_empty, f_af, f_ae, f_ovf, f_unf}),
            32'({n == DEPTH, n == 0, n >= DEPTH - 2, n <= 2, m_ovf, m_unf}));
        chk("fwft_valid", 32'(f_rd_valid), 32'(n != 0));
        if (n != 0) chk("fwft_data", 32'(f_rd_data), 32'(q[0]));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic drv(input bit rs, input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        rst = rs; w_inc = w; wr_data = d; r_inc = r; clr_err = c;
        cyc();
    endtask

    initial begin
        rst = 1'b1; w_inc = 1'b0; r_inc = 1'b0; clr_err = 1'b0; wr_data = '0;

        //          rst w  d      r  clr cnt fu em ov un sv sd
        tbl[0]  = mk(1, 0, 8'h00, 0, 0,  0,  0, 1, 0, 0, 0, 8'h00);
        tbl[1]  = mk(0, 0, 8'h00, 1, 0,  0,  0, 1, 0, 1, 0, 8'h00);
        tbl[2]  = mk(0, 0, 8'h00, 1, 1,  0,  0, 1, 0, 1, 0, 8'h00);
        tbl[3]  = mk(0, 0, 8'h00, 0, 1,  0,  0, 1, 0, 0, 0, 8'h00);
        tbl[4]  = mk(0, 1, 8'h11, 1, 0,  1,  0, 0, 0, 1, 0, 8'h00);
        tbl[5]  = mk(0, 0, 8'h00, 0, 1,  1,  0, 0, 0, 0, 0, 8'h00);
        tbl[6]  = mk(0, 1, 8'h22, 0, 0,  2,  0, 0, 0, 0, 0, 8'h00);
        tbl[7]  = mk(0, 0, 8'h00, 1, 0,  1,  0, 0, 0, 0, 1, 8'h11);
        tbl[8]  = mk(0, 0, 8'h00, 0, 0,  1,  0, 0, 0, 0, 0, 8'h11);
        tbl[9]  = mk(0, 1, 8'h33, 1, 0,  1,  0, 0, 0, 0, 1, 8'h22);
        tbl[10] = mk(0, 0, 8'h00, 1, 0,  0,  0, 1, 0, 0, 1, 8'h33);
        tbl[11] = mk(0, 0, 8'h00, 0, 0,  0,  0, 1, 0, 0, 0, 8'h33);

        for (int i = 0; i < 12; i++) begin
            drv(tbl[i].rst, tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].clr);
            chk("tbl_count", 32'(s_count), 32'(tbl[i].cnt));
            chk("tbl_full_empty", 32'({s_full, s_empty}), 32'({tbl[i].full, tbl[i].empty}));
            chk("tbl_err", 32'({s_ovf, s_unf}), 32'({tbl[i].ovf, tbl[i].unf}));
            chk("tbl_std_valid", 32'(s_rd_valid), 32'(tbl[i].sv));
            chk("tbl_std_data", 32'(s_rd_data), 32'(tbl[i].sd));
        end

        // Reset values, then fill to FULL and overflow
        drv(1, 0, 8'h00, 0, 0);
        chk("rst_status", 32'({s_full, s_empty, s_af, s_ae, s_ovf, s_unf, s_rd_valid}),
            32'(7'b0101000));
        chk("rst_rd_data", 32'(s_rd_data), 32'h0);
        for (int k = 1; k <= 8; k++) begin
            drv(0, 1, DW'(k), 0, 0);
            chk("fill_count", 32'(s_count), 32'(k));
            chk("fill_af", 32'(s_af), 32'(k >= 6));
            chk("fill_full", 32'(s_full), 32'(k == 8));
        end
        drv(0, 1, 8'hFF, 0, 0);
        chk("ovf_set", 32'(s_ovf), 32'h1);
        chk("ovf_count", 32'(s_count), 32'h8);
        for (int k = 1; k <= 8; k++) begin
            chk("drain_fwft_head", 32'(f_rd_data), 32'(k));
            drv(0, 0, 8'h00, 1, 0);
            chk("drain_std_data", 32'(s_rd_data), 32'(k));
        end
        chk("drain_empty", 32'(s_empty), 32'h1);

        // Steady-state simultaneous read/write across pointer wrap
        drv(1, 0, 8'h00, 0, 0);
        for (int k = 0; k < 4; k++) drv(0, 1, DW'(8'h40 + k), 0, 0);
        for (int k = 0; k < 20; k++) begin
            drv(0, 1, DW'(8'h44 + k), 1, 0);
            chk("rw_count", 32'(s_count), 32'h4);
            chk("rw_std_data", 32'(s_rd_data), 32'(8'h40 + k));
        end

        // FWFT fall-through of a single word
        drv(1, 0, 8'h00, 0, 0);
        drv(0, 1, 8'hA5, 0, 0);
        chk("fwft_fall_valid", 32'(f_rd_valid), 32'h1);
        chk("fwft_fall_data", 32'(f_rd_data), 32'hA5);
        drv(0, 0, 8'h00, 0, 0);
        chk("fwft_hold_data", 32'(f_rd_data), 32'hA5);
        drv(0, 0, 8'h00, 1, 0);
        chk("fwft_pop_empty", 32'({f_empty, f_rd_valid}), 32'(2'b10));

        // Reset mid-burst with an error flag pending
        drv(0, 0, 8'h00, 1, 0);
        for (int k = 0; k < 5; k++) drv(0, 1, DW'(8'h60 + k), 0, 0);
        chk("pre_rst_count", 32'(s_count), 32'h5);
        drv(1, 1, 8'h77, 1, 0);
        chk("mid_rst_count", 32'(s_count), 32'h0);
        chk("mid_rst_flags", 32'({s_empty, s_rd_valid, f_rd_valid, s_ovf, s_unf}), 32'(5'b10000));

        // Randomised traffic with shifting fill bias
        drv(1, 0, 8'h00, 0, 0);
        for (int k = 0; k < 3000; k++) begin
            int wb;
            wb = ((k / 300) % 2 == 0) ? 70 : 35;
            drv($urandom_range(0, 199) == 0,
                $urandom_range(0, 99) < wb,
                DW'($urandom),
                $urandom_range(0, 99) < 50,
                $urandom_range(0, 15) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
